// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit multi-cycle CPU: opcodes, control-unit states and
// datapath mux/ALU encodings.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StRtExec   = 4'd6,
    StRtWb     = 4'd7,
    StBranch   = 4'd8,
    StJump     = 4'd9,
    StAddiEx   = 4'd10,
    StAddiWb   = 4'd11,
    StHalt     = 4'd15
  } state_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_ONE   = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_SHIMM = 2'b11;

endpackage

// File: rtl/cu_multicycle.sv
// Multi-cycle control unit: sequences the shared ALU/memory datapath through
// fetch/decode/execute/mem/write-back, stalling on mem_ready.
module cu_multicycle
  import cpu_pkg::*;
#(
  parameter int unsigned OPW = 6
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [OPW-1:0] opcode,
  input  logic           mem_ready,
  output logic           PCWrite,
  output logic           PCWriteCond,
  output logic           IorD,
  output logic           MemRead,
  output logic           MemWrite,
  output logic           IRWrite,
  output logic           MemToReg,
  output logic           RegDst,
  output logic           RegWrite,
  output logic           ALUSrcA,
  output logic [1:0]     ALUSrcB,
  output logic [1:0]     ALUOp,
  output logic [1:0]     PCSource,
  output logic           illegal_op,
  output logic           halted,
  output logic [3:0]     state
);

  state_e state_q, state_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Reset forces every output low in the same cycle, not just after the edge.
  assign state = reset ? 4'd0 : state_q;

  always_comb begin
    state_d     = StFetch;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemToReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_B;
    ALUOp       = ALUOP_ADD;
    PCSource    = PCSRC_ALU;
    illegal_op  = 1'b0;
    halted      = 1'b0;
    if (!reset) begin
      case (state_q)
        StFetch: begin
          MemRead = 1'b1;
          ALUSrcB = SRCB_ONE;
          PCWrite = mem_ready;
          IRWrite = mem_ready;
          state_d = mem_ready ? StDecode : StFetch;
        end
        StDecode: begin
          ALUSrcB = SRCB_SHIMM;
          case (opcode)
            OPW'(OP_RTYPE):          state_d = StRtExec;
            OPW'(OP_LW), OPW'(OP_SW): state_d = StMemAddr;
            OPW'(OP_BEQ):            state_d = StBranch;
            OPW'(OP_J):              state_d = StJump;
            OPW'(OP_ADDI):           state_d = StAddiEx;
            OPW'(OP_HALT):           state_d = StHalt;
            default: begin
              illegal_op = 1'b1;
              state_d    = StFetch;
            end
          endcase
        end
        StMemAddr: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
          state_d = (opcode == OPW'(OP_LW)) ? StMemRead : StMemWrite;
        end
        StMemRead: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
          state_d = mem_ready ? StMemWb : StMemRead;
        end
        StMemWb: begin
          RegWrite = 1'b1;
          MemToReg = 1'b1;
        end
        StMemWrite: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
          state_d  = mem_ready ? StFetch : StMemWrite;
        end
        StRtExec: begin
          ALUSrcA = 1'b1;
          ALUOp   = ALUOP_FUNCT;
          state_d = StRtWb;
        end
        StRtWb: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        StBranch: begin
          ALUSrcA     = 1'b1;
          ALUOp       = ALUOP_SUB;
          PCWriteCond = 1'b1;
          PCSource    = PCSRC_ALUOUT;
        end
        StJump: begin
          PCWrite  = 1'b1;
          PCSource = PCSRC_JUMP;
        end
        StAddiEx: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
          state_d = StAddiWb;
        end
        StAddiWb: begin
          RegWrite = 1'b1;
        end
        StHalt: begin
          halted  = 1'b1;
          state_d = StHalt;
        end
        default: state_d = StFetch;
      endcase
    end
  end

endmodule

// File: tb/tb_cu_multicycle.sv
// Directed bench for cu_multicycle: per-cycle expected output vectors are queued as stimulus
// is driven and compared at the following falling edge.
module tb_cu_multicycle;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemToReg, RegDst, RegWrite, ALUSrcA, illegal_op, halted;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [21:0] v;
  } exp_t;
  exp_t sb[$];

  logic [21:0] obs;
  assign obs = {state, halted, illegal_op, PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
                IRWrite, MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

  cu_multicycle #(.OPW(6)) dut (
    .clock       (clock),
    .reset       (reset),
    .opcode      (opcode),
    .mem_ready   (mem_ready),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemToReg    (MemToReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .PCSource    (PCSource),
    .illegal_op  (illegal_op),
    .halted      (halted),
    .state       (state)
  );

  always #5 clock = ~clock;

  // f = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst, RegWrite,
  //      ALUSrcA}
  function automatic logic [21:0] mk(input logic [3:0] st, input logic hl, input logic il,
                                     input logic [9:0] f, input logic [1:0] srcb,
                                     input logic [1:0] aop, input logic [1:0] pcs);
    return {st, hl, il, f, srcb, aop, pcs};
  endfunction

  function automatic logic [21:0] e_fetch(input logic mr);
    return mk(4'd0, 1'b0, 1'b0, {mr, 2'b00, 1'b1, 1'b0, mr, 4'b0000}, 2'b01, 2'b00, 2'b00);
  endfunction
  function automatic logic [21:0] e_decode(input logic il);
    return mk(4'd1, 1'b0, il, 10'b0, 2'b11, 2'b00, 2'b00);
  endfunction

  localparam logic [21:0] E_ZERO = 22'd0;
  localparam logic [21:0] E_MEMADDR  = {4'd2,  2'b00, 10'b0000000001, 2'b10, 2'b00, 2'b00};
  localparam logic [21:0] E_MEMREAD  = {4'd3,  2'b00, 10'b0011000000, 2'b00, 2'b00, 2'b00};
  localparam logic [21:0] E_MEMWB    = {4'd4,  2'b00, 10'b0000001010, 2'b00, 2'b00, 2'b00};
  localparam logic [21:0] E_MEMWRITE = {4'd5,  2'b00, 10'b0010100000, 2'b00, 2'b00, 2'b00};
  localparam logic [21:0] E_RTEXEC   = {4'd6,  2'b00, 10'b0000000001, 2'b00, 2'b10, 2'b00};
  localparam logic [21:0] E_RTWB     = {4'd7,  2'b00, 10'b0000000110, 2'b00, 2'b00, 2'b00};
  localparam logic [21:0] E_BRANCH   = {4'd8,  2'b00, 10'b0100000001, 2'b00, 2'b01, 2'b01};
  localparam logic [21:0] E_JUMP     = {4'd9,  2'b00, 10'b1000000000, 2'b00, 2'b00, 2'b10};
  localparam logic [21:0] E_ADDIEX   = {4'd10, 2'b00, 10'b0000000001, 2'b10, 2'b00, 2'b00};
  localparam logic [21:0] E_ADDIWB   = {4'd11, 2'b00, 10'b0000000010, 2'b00, 2'b00, 2'b00};
  localparam logic [21:0] E_HALT     = {4'd15, 2'b10, 10'b0000000000, 2'b00, 2'b00, 2'b00};

  // Drive one cycle of inputs, queue its expectation, check at the falling edge, then advance.
  task automatic step(input string tag, input logic rst, input logic [5:0] op,
                      input logic mr, input logic [21:0] e);
    exp_t x;
    reset     = rst;
    opcode    = op;
    mem_ready = mr;
    sb.push_back('{tag: tag, v: e});
    @(negedge clock);
    x = sb.pop_front();
    checks++;
    assert (obs === x.v)
    else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", x.tag, obs, x.v);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    step("reset",        1'b1, 6'b000000, 1'b1, E_ZERO);
    // R-type, mem_ready ignored outside wait states
    step("rt_fetch",     1'b0, 6'b000000, 1'b1, e_fetch(1'b1));
    step("rt_decode",    1'b0, 6'b000000, 1'b1, e_decode(1'b0));
    step("rt_exec",      1'b0, 6'b000000, 1'b0, E_RTEXEC);
    step("rt_wb",        1'b0, 6'b000000, 1'b0, E_RTWB);
    // lw with two wait cycles in MEMREAD
    step("lw_fetch",     1'b0, 6'b100011, 1'b1, e_fetch(1'b1));
    step("lw_decode",    1'b0, 6'b100011, 1'b1, e_decode(1'b0));
    step("lw_memaddr",   1'b0, 6'b100011, 1'b0, E_MEMADDR);
    step("lw_memread0",  1'b0, 6'b100011, 1'b0, E_MEMREAD);
    step("lw_memread1",  1'b0, 6'b100011, 1'b0, E_MEMREAD);
    step("lw_memread2",  1'b0, 6'b100011, 1'b1, E_MEMREAD);
    step("lw_memwb",     1'b0, 6'b100011, 1'b1, E_MEMWB);
    // sw with three fetch wait cycles and one MEMWRITE wait
    step("sw_fetchw0",   1'b0, 6'b101011, 1'b0, e_fetch(1'b0));
    step("sw_fetchw1",   1'b0, 6'b101011, 1'b0, e_fetch(1'b0));
    step("sw_fetchw2",   1'b0, 6'b101011, 1'b0, e_fetch(1'b0));
    step("sw_fetch",     1'b0, 6'b101011, 1'b1, e_fetch(1'b1));
    step("sw_decode",    1'b0, 6'b101011, 1'b1, e_decode(1'b0));
    step("sw_memaddr",   1'b0, 6'b101011, 1'b1, E_MEMADDR);
    step("sw_memwrite0", 1'b0, 6'b101011, 1'b0, E_MEMWRITE);
    step("sw_memwrite1", 1'b0, 6'b101011, 1'b1, E_MEMWRITE);
    // beq then j
    step("beq_fetch",    1'b0, 6'b000100, 1'b1, e_fetch(1'b1));
    step("beq_decode",   1'b0, 6'b000100, 1'b1, e_decode(1'b0));
    step("beq_branch",   1'b0, 6'b000100, 1'b0, E_BRANCH);
    step("j_fetch",      1'b0, 6'b000010, 1'b1, e_fetch(1'b1));
    step("j_decode",     1'b0, 6'b000010, 1'b1, e_decode(1'b0));
    step("j_jump",       1'b0, 6'b000010, 1'b0, E_JUMP);
    // addi
    step("addi_fetch",   1'b0, 6'b001000, 1'b1, e_fetch(1'b1));
    step("addi_decode",  1'b0, 6'b001000, 1'b1, e_decode(1'b0));
    step("addi_ex",      1'b0, 6'b001000, 1'b1, E_ADDIEX);
    step("addi_wb",      1'b0, 6'b001000, 1'b1, E_ADDIWB);
    // illegal opcode: one-cycle pulse, straight back to FETCH
    step("ill_fetch",    1'b0, 6'b010101, 1'b1, e_fetch(1'b1));
    step("ill_decode",   1'b0, 6'b010101, 1'b1, e_decode(1'b1));
    step("ill_after",    1'b0, 6'b010101, 1'b0, e_fetch(1'b0));
    step("ill_after2",   1'b0, 6'b111111, 1'b1, e_fetch(1'b1));
    // HALT for ten cycles, then reset mid-HALT
    step("halt_decode",  1'b0, 6'b111111, 1'b1, e_decode(1'b0));
    for (int i = 0; i < 10; i++) begin
      step($sformatf("halt_%0d", i), 1'b0, 6'b111111, 1'(i % 2), E_HALT);
    end
    step("halt_reset",   1'b1, 6'b111111, 1'b1, E_ZERO);
    step("post_reset",   1'b0, 6'b101011, 1'b1, e_fetch(1'b1));
    // reset during a MEMWRITE wait drops MemWrite immediately
    step("sw2_decode",   1'b0, 6'b101011, 1'b1, e_decode(1'b0));
    step("sw2_memaddr",  1'b0, 6'b101011, 1'b1, E_MEMADDR);
    step("sw2_memwrite", 1'b0, 6'b101011, 1'b0, E_MEMWRITE);
    step("sw2_reset",    1'b1, 6'b101011, 1'b0, E_ZERO);
    step("sw2_post",     1'b0, 6'b101011, 1'b0, e_fetch(1'b0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cu_multicycle.md
Name: cu_multicycle

Overview:
- Multi-cycle control unit FSM that sequences the shared 16-bit datapath (single ALU, single unified memory) across FETCH/DECODE/EXECUTE/MEM/WB steps.
- Drop-in sibling of the single-cycle control unit: same opcode input, same control-signal names plus multi-cycle extras.
- Stalls on a memory ready handshake; supports a HALT opcode.

Parameters:
- OPW, 6, opcode field width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; takes effect on the next rising edge.
- opcode  in  OPW  instruction opcode from the instruction register (valid from DECODE onward).
- mem_ready  in  1  memory completes the current access this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load if ALU zero.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction register load.
- MemToReg  out  1  write-back select: 1 = MDR.
- RegDst  out  1  destination register select: 1 = rd.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  0 = PC, 1 = register A.
- ALUSrcB  out  2  00 = B, 01 = const 1, 10 = sign-extended immediate, 11 = shifted immediate.
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct decode.
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- illegal_op  out  1  one-cycle pulse on an undefined opcode.
- halted  out  1  high while in HALT.
- state  out  4  current state, for debug.

Behaviour:
- Reset: while reset is high, every output is 0 (including state and halted); the state register loads FETCH on the clock edge.
- Reset has priority over every state, wait, or HALT condition.
- State encodings:
  - FETCH = 0, DECODE = 1, MEMADDR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5
  - RTEXEC = 6, RTWB = 7, BRANCH = 8, JUMP = 9, ADDIEX = 10, ADDIWB = 11, HALT = 15
  - Codes 12–14 are unreachable; if entered, go to FETCH.
- Outputs are Moore, except PCWrite and IRWrite in FETCH, which are gated by mem_ready. Signals not listed for a state are 0.
- FETCH:
  - MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, PCSource = 00.
  - PCWrite = IRWrite = mem_ready.
  - Stay in FETCH while mem_ready = 0; go to DECODE when mem_ready = 1.
- DECODE: ALUSrcA = 0, ALUSrcB = 11, ALUOp = 00. Next state by opcode:
  - 000000 -> RTEXEC
  - 100011 or 101011 -> MEMADDR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 -> ADDIEX
  - 111111 -> HALT
  - anything else -> FETCH, with illegal_op = 1 for this cycle.
- MEMADDR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Next is MEMREAD for load (100011), MEMWRITE for store (101011).
- MEMREAD: MemRead = 1, IorD = 1. Waits on mem_ready, then MEMWB.
- MEMWB: RegWrite = 1, MemToReg = 1, RegDst = 0. Next FETCH.
- MEMWRITE: MemWrite = 1, IorD = 1. Waits on mem_ready, then FETCH. MemWrite stays high for every waiting cycle.
- RTEXEC: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10. Next RTWB.
- RTWB: RegWrite = 1, RegDst = 1, MemToReg = 0. Next FETCH.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCWriteCond = 1, PCSource = 01. Next FETCH.
- JUMP: PCWrite = 1, PCSource = 10. Next FETCH.
- ADDIEX: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Next ADDIWB.
- ADDIWB: RegWrite = 1, RegDst = 0, MemToReg = 0. Next FETCH.
- HALT: halted = 1, all other outputs 0. Stays until reset.
- Latency with zero wait states, FETCH to the next FETCH: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4, illegal 2.
- Each wait cycle (mem_ready = 0 in FETCH, MEMREAD or MEMWRITE) adds 1 cycle.
- mem_ready is ignored in every other state.
- MemRead and MemWrite are never asserted in the same cycle.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_HALT
  - the state enum (4-bit)
  - ALUOp and PCSource encodings
  - the ALUSrcB encodings.
- Single module; no sub-module is needed. Structure it as a state register plus a combinational next-state/output block.

Test Plan:
- Reset, then opcode = 000000 with mem_ready = 1 held:
  - states go 0, 1, 6, 7, 0.
  - RegWrite = 1 with RegDst = 1 only in the RTWB cycle.
  - PCWrite = IRWrite = 1 only in FETCH.
- lw (100011) with mem_ready low for 2 cycles in MEMREAD:
  - MEMREAD is held 3 cycles with MemRead = 1 and IorD = 1.
  - Total is 7 cycles from FETCH to the next FETCH.
  - RegWrite = 1 with MemToReg = 1 in MEMWB.
- sw (101011) with mem_ready = 0 for 3 FETCH cycles:
  - PCWrite = 0 and IRWrite = 0 during the wait.
  - Both assert in the cycle mem_ready rises.
  - MemWrite = 1 throughout MEMWRITE.
- beq (000100), then j (000010):
  - BRANCH has PCWriteCond = 1, ALUOp = 01, PCSource = 01.
  - JUMP has PCWrite = 1, PCSource = 10.
  - Each takes 3 cycles.
- Opcode 010101:
  - illegal_op pulses for exactly 1 cycle in DECODE.
  - The next state is FETCH; no RegWrite or MemWrite is asserted.
- Opcode 111111, then reset asserted mid-HALT:
  - halted = 1 for 10 cycles.
  - During the reset cycle, all outputs are 0.
  - The state is FETCH on the edge after reset.
  - Additionally, reset asserted in MEMWRITE drops MemWrite in the same cycle.
